// File: rtl/mux_32_pkg.sv
// Shared types and constants for the 32-to-1 word multiplexer.
// Used by mux_32 (optional hold feature: MUX_32_HOLD_EN) and its mux_2 tree.
package mux_32_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;
  localparam int NUM_IN = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

  // Offset of a tree level within the flat node array.
  // Level 0 holds the raw inputs, and level SEL_W holds the final output.
  function automatic int nodeBase(input int lvl);
    return (2 * NUM_IN) - ((2 * NUM_IN) >> lvl);
  endfunction

endpackage

// File: rtl/mux_32_mux_2.sv
// 2:1 WIDTH-bit multiplexer, the leaf cell of the mux_32 selection tree.
module mux_2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_32.sv
// 32-to-1 word mux with combinational output and a registered copy (out_q).
// Define MUX_32_HOLD_EN to add a 'hold' input that freezes out_q.
module mux_32 #(
  parameter int WIDTH = mux_32_pkg::DATA_W,
  parameter int SEL_W = mux_32_pkg::SEL_W
) (
  output logic [WIDTH-1:0] out,
  input  logic [SEL_W-1:0] select,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  logic [WIDTH-1:0] in16,
  input  logic [WIDTH-1:0] in17,
  input  logic [WIDTH-1:0] in18,
  input  logic [WIDTH-1:0] in19,
  input  logic [WIDTH-1:0] in20,
  input  logic [WIDTH-1:0] in21,
  input  logic [WIDTH-1:0] in22,
  input  logic [WIDTH-1:0] in23,
  input  logic [WIDTH-1:0] in24,
  input  logic [WIDTH-1:0] in25,
  input  logic [WIDTH-1:0] in26,
  input  logic [WIDTH-1:0] in27,
  input  logic [WIDTH-1:0] in28,
  input  logic [WIDTH-1:0] in29,
  input  logic [WIDTH-1:0] in30,
  input  logic [WIDTH-1:0] in31,
  input  logic             clock,
  input  logic             reset,
`ifdef MUX_32_HOLD_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] out_q
);

  import mux_32_pkg::*;

  localparam int NUM_NODES = 2 * NUM_IN - 1;

  logic [WIDTH-1:0] w_in   [0:NUM_IN-1];
  logic [WIDTH-1:0] w_node [0:NUM_NODES-1];
  logic [WIDTH-1:0] r_outQ;

  assign w_in = '{in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
                  in8,  in9,  in10, in11, in12, in13, in14, in15,
                  in16, in17, in18, in19, in20, in21, in22, in23,
                  in24, in25, in26, in27, in28, in29, in30, in31};

  genvar gLeaf, gLvl, gIdx;

  for (gLeaf = 0; gLeaf < NUM_IN; gLeaf++) begin : g_leaf
    assign w_node[gLeaf] = w_in[gLeaf];
  end

  // Binary tree: level k pairs up neighbours using select bit k, LSB at the leaves.
  for (gLvl = 0; gLvl < SEL_W; gLvl++) begin : g_lvl
    for (gIdx = 0; gIdx < (NUM_IN >> (gLvl + 1)); gIdx++) begin : g_mux
      mux_2 #(.WIDTH(WIDTH)) u_mux (
        .i_a   (w_node[nodeBase(gLvl) + 2 * gIdx]),
        .i_b   (w_node[nodeBase(gLvl) + 2 * gIdx + 1]),
        .i_sel (select[gLvl]),
        .o_y   (w_node[nodeBase(gLvl + 1) + gIdx])
      );
    end
  end

  assign out = w_node[NUM_NODES-1];

  // Pipelined copy of out; reset clears it asynchronously and takes priority over hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outQ <= '0;
    end
`ifdef MUX_32_HOLD_EN
    else if (!hold) begin
      r_outQ <= out;
    end
`else
    else begin
      r_outQ <= out;
    end
`endif
  end

  assign out_q = r_outQ;

endmodule

// File: tb/tb_mux_32.sv
// Self-checking bench for mux_32: directed scenarios plus random stimulus
// checked against an array-lookup reference model.
`timescale 1ns/1ps
module tb_mux_32;

  logic        clock;
  logic        reset;
  logic [4:0]  select;
  logic [31:0] inArr [0:31];
  logic [31:0] out;
  logic [31:0] out_q;
`ifdef MUX_32_HOLD_EN
  logic        hold;
`endif

  int checks;
  int failures;

  mux_32 dut (
    .out(out), .select(select),
    .in0(inArr[0]),   .in1(inArr[1]),   .in2(inArr[2]),   .in3(inArr[3]),
    .in4(inArr[4]),   .in5(inArr[5]),   .in6(inArr[6]),   .in7(inArr[7]),
    .in8(inArr[8]),   .in9(inArr[9]),   .in10(inArr[10]), .in11(inArr[11]),
    .in12(inArr[12]), .in13(inArr[13]), .in14(inArr[14]), .in15(inArr[15]),
    .in16(inArr[16]), .in17(inArr[17]), .in18(inArr[18]), .in19(inArr[19]),
    .in20(inArr[20]), .in21(inArr[21]), .in22(inArr[22]), .in23(inArr[23]),
    .in24(inArr[24]), .in25(inArr[25]), .in26(inArr[26]), .in27(inArr[27]),
    .in28(inArr[28]), .in29(inArr[29]), .in30(inArr[30]), .in31(inArr[31]),
    .clock(clock), .reset(reset),
`ifdef MUX_32_HOLD_EN
    .hold(hold),
`endif
    .out_q(out_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives in_k = k+1 so every input is distinct and easy to recognise.
  task automatic setRamp();
    for (int k = 0; k < 32; k++) inArr[k] = 32'(k + 1);
  endtask

  task automatic test_reset();
    setRamp();
    select = 5'd9;
    @(posedge clock);
    #1;
    checks++;
    if (out_q !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold out_q=%h expected=%h", out_q, 32'd0);
    end
    checks++;
    if (out !== 32'd10) begin
      failures++;
      $display("[TB] FAIL reset_out out=%h expected=%h", out, 32'd10);
    end
  endtask

  task automatic test_comb_sweep();
    setRamp();
    for (int s = 0; s < 32; s++) begin
      select = 5'(s);
      #0.1;
      checks++;
      if (out !== 32'(s + 1)) begin
        failures++;
        $display("[TB] FAIL comb_sweep sel=%0d out=%h expected=%h", s, out, 32'(s + 1));
      end
    end
  endtask

  task automatic test_input_change();
    setRamp();
    select = 5'd13;
    #0.1;
    inArr[13] = 32'hDEADBEEF;
    #0.1;
    checks++;
    if (out !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL input_change out=%h expected=%h", out, 32'hDEADBEEF);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    reset = 1'b0;
    setRamp();
    select = 5'd20;
    @(posedge clock);
    #1;
    checks++;
    if (out_q !== 32'd21) begin
      failures++;
      $display("[TB] FAIL preload out_q=%h expected=%h", out_q, 32'd21);
    end
    #1;
    reset = 1'b1;
    #0.5;
    checks++;
    if (out_q !== 32'd0) begin
      failures++;
      $display("[TB] FAIL async_clear out_q=%h expected=%h", out_q, 32'd0);
    end
    checks++;
    if (out !== 32'd21) begin
      failures++;
      $display("[TB] FAIL reset_no_out_effect out=%h expected=%h", out, 32'd21);
    end
    @(negedge clock);
    select = 5'd7;
    reset  = 1'b0;
    #1;
    checks++;
    if (out_q !== 32'd0) begin
      failures++;
      $display("[TB] FAIL release_wait out_q=%h expected=%h", out_q, 32'd0);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_q !== 32'd8) begin
      failures++;
      $display("[TB] FAIL release_load out_q=%h expected=%h", out_q, 32'd8);
    end
  endtask

  task automatic test_clocked_sweep();
    setRamp();
    for (int n = 0; n < 32; n++) begin
      @(negedge clock);
      select = 5'(n);
      @(posedge clock);
      #1;
      checks++;
      if (out_q !== 32'(n + 1)) begin
        failures++;
        $display("[TB] FAIL clocked_sweep n=%0d out_q=%h expected=%h", n, out_q, 32'(n + 1));
      end
    end
  endtask

  task automatic test_alternating();
    logic [31:0] expVal;
    setRamp();
    inArr[0]  = 32'hFFFFFFFF;
    inArr[31] = 32'h00000000;
    for (int t = 0; t < 6; t++) begin
      @(negedge clock);
      select = (t % 2 == 0) ? 5'd0 : 5'd31;
      expVal = (t % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000;
      #1;
      checks++;
      if (out !== expVal) begin
        failures++;
        $display("[TB] FAIL alternating_out t=%0d out=%h expected=%h", t, out, expVal);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_q !== expVal) begin
        failures++;
        $display("[TB] FAIL alternating_q t=%0d out_q=%h expected=%h", t, out_q, expVal);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] expVal;
    int          sel;
    for (int it = 0; it < 100; it++) begin
      @(negedge clock);
      for (int k = 0; k < 32; k++) inArr[k] = $urandom;
      sel    = int'($urandom_range(0, 31));
      select = 5'(sel);
      expVal = inArr[sel];
      #1;
      checks++;
      if (out !== expVal) begin
        failures++;
        $display("[TB] FAIL random_out sel=%0d out=%h expected=%h", sel, out, expVal);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_q !== expVal) begin
        failures++;
        $display("[TB] FAIL random_q sel=%0d out_q=%h expected=%h", sel, out_q, expVal);
      end
    end
  endtask

`ifdef MUX_32_HOLD_EN
  task automatic test_hold();
    setRamp();
    @(negedge clock);
    hold   = 1'b0;
    select = 5'd4;
    @(posedge clock);
    #1;
    checks++;
    if (out_q !== 32'd5) begin
      failures++;
      $display("[TB] FAIL hold_load out_q=%h expected=%h", out_q, 32'd5);
    end
    @(negedge clock);
    hold   = 1'b1;
    select = 5'd20;
    #1;
    checks++;
    if (out !== 32'd21) begin
      failures++;
      $display("[TB] FAIL hold_out out=%h expected=%h", out, 32'd21);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #1;
      checks++;
      if (out_q !== 32'd5) begin
        failures++;
        $display("[TB] FAIL hold_keep c=%0d out_q=%h expected=%h", c, out_q, 32'd5);
      end
    end
    @(negedge clock);
    hold = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (out_q !== 32'd21) begin
      failures++;
      $display("[TB] FAIL hold_release out_q=%h expected=%h", out_q, 32'd21);
    end
    @(negedge clock);
    hold  = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_q !== 32'd0) begin
      failures++;
      $display("[TB] FAIL hold_reset out_q=%h expected=%h", out_q, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    hold  = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    select   = 5'd0;
`ifdef MUX_32_HOLD_EN
    hold     = 1'b0;
`endif
    for (int k = 0; k < 32; k++) inArr[k] = 32'd0;

    test_reset();
    test_comb_sweep();
    test_input_change();
    test_async_reset();
    test_clocked_sweep();
    test_alternating();
    test_random();
`ifdef MUX_32_HOLD_EN
    test_hold();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_32.md
Name: mux_32

Overview:
- 32-to-1 word multiplexer, 32-bit data, 5-bit select.
- Used in the processor datapath (register-file read ports, writeback/operand selection).
- Provides an immediate combinational output for same-cycle use.
- Also provides a registered copy of that output for pipelined consumers.

Parameters:
- WIDTH, 32, data width of every input and both outputs.
- SEL_W, 5, select width; fixed at 5, which gives 32 inputs. Not intended to be overridden.

Ports:
- clock  input  1  single system clock; all sequential logic on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears out_q.
- out  output  WIDTH  combinational selected word.
- select  input  SEL_W  index of the input to route; in0 = 0 ... in31 = 31.
- in0 .. in31  input  WIDTH each  data inputs, 32 separate ports.
- out_q  output  WIDTH  registered version of out.
- Port order for positional instantiation: out, select, in0..in31.
- clock, reset and out_q are connected by name only.

Behaviour:
- out = in[select], purely combinational, zero-cycle latency.
- out depends on no clock or state and updates whenever select or any input changes.
- Every select value 0..31 is legal; there is no out-of-range case.
- If select contains X or Z bits, out may be X. No X-pessimism masking is required.
- out_q captures out on every rising clock edge, giving 1-cycle latency.
- Reset: out_q = 0 immediately on reset assertion, without waiting for a clock edge.
- out_q is held at 0 while reset is high.
- On the first rising edge after reset deasserts, out_q loads the current out.
- Reset asserted mid-stream: out_q clears asynchronously. out is unaffected by reset at all times.
- No handshake and no FSM.
- Width rule: all data paths are exactly WIDTH bits, with no sign or zero extension.

Optional Feature:
- Macro: MUX_32_HOLD_EN.
- When defined: adds input port hold (1 bit, placed after reset).
  - While hold = 1, out_q keeps its value on rising edges.
  - While hold = 0, out_q loads out.
  - reset overrides hold.
  - out is unaffected by hold.
- When undefined: no hold port; out_q loads out every cycle.

Decomposition:
- Shared package mux_32_pkg holds:
  - localparams DATA_W = 32, SEL_W = 5, NUM_IN = 32;
  - typedef word_t (logic [DATA_W-1:0]);
  - typedef sel_t (logic [SEL_W-1:0]).
- Natural sub-module: mux_2, a 2:1 WIDTH-bit mux.
  - Instantiate 31 copies as a 5-level binary tree: level k is driven by select bit k, LSB at the leaf level.
- The output register is a single always block inside mux_32.

Test Plan:
- Inputs in_k = k+1 (in0 = 1 ... in31 = 32); sweep select 0..31 with 0.1 ns steps -> out = select+1 at each step, e.g. select = 00000 -> 1, select = 11111 -> 32.
- Same inputs, select = 13, change in13 to 0xDEADBEEF -> out = 0xDEADBEEF in the same delta cycle, with no clock needed.
- reset = 1 asynchronously between clock edges -> out_q = 0 immediately. Release reset with select = 7 -> out_q = 8 after the next rising edge, one cycle behind out.
- Clocked sweep of select 0..31, one value per cycle -> out_q at cycle n+1 equals n+1.
- Alternating patterns: in0 = 0xFFFFFFFF, in31 = 0x00000000, toggle select 0 <-> 31 -> out toggles all 32 bits with no stuck bits.
- With MUX_32_HOLD_EN defined: load out_q = 5 (select = 4), set hold = 1, change select to 20 -> out = 21 and out_q stays 5. Release hold -> out_q = 21 after the next edge.
